// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock supervisor: pulses the PLL reset, waits for a stable synchronised lock, then releases sys_rst_n.
// Optional lock statistics counters are enabled with the PLL_LOCK_STATS_EN macro.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 500000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned CNT_W         = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       lock_ok,
`ifdef PLL_LOCK_STATS_EN
  output logic [7:0] retry_cnt,
  output logic [7:0] loss_cnt,
`endif
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    ST_PLL_RESET = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LOAD = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, lk_q;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             lock_ok_q, lock_ok_d;
  logic             cnt_zero_s;
  logic             retry_ev_s, loss_ev_s;

  assign cnt_zero_s = (cnt_q == CNT_ZERO);

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      lk_q    <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      lk_q    <= sync1_q;
    end
  end

  // Next-state, counter reload and output decode from the next state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retry_ev_s = 1'b0;
    loss_ev_s  = 1'b0;
    case (state_q)
      ST_PLL_RESET: begin
        if (cnt_zero_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = TO_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a timeout expiring in the same cycle.
        if (lk_q) begin
          state_d = ST_STABLE;
          cnt_d   = STABLE_LOAD;
        end else if (cnt_zero_s) begin
          state_d    = ST_PLL_RESET;
          cnt_d      = RST_LOAD;
          retry_ev_s = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_STABLE: begin
        if (!lk_q) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = TO_LOAD;
        end else if (cnt_zero_s) begin
          state_d = ST_RUN;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RUN: begin
        if (!lk_q) begin
          state_d   = ST_WAIT_LOCK;
          cnt_d     = TO_LOAD;
          loss_ev_s = 1'b1;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      default: begin
        state_d = ST_PLL_RESET;
        cnt_d   = RST_LOAD;
      end
    endcase
    pll_rst_d   = (state_d == ST_PLL_RESET);
    sys_rst_n_d = (state_d == ST_RUN);
    lock_ok_d   = (state_d == ST_RUN);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PLL_RESET;
      cnt_q       <= RST_LOAD;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      lock_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      lock_ok_q   <= lock_ok_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign lock_ok   = lock_ok_q;
  assign state_o   = state_q;

`ifdef PLL_LOCK_STATS_EN
  logic [7:0] retry_q, retry_d;
  logic [7:0] loss_q, loss_d;

  // Saturating event counters.
  always_comb begin
    if (retry_ev_s && (retry_q != 8'hFF)) begin
      retry_d = retry_q + 8'd1;
    end else begin
      retry_d = retry_q;
    end
    if (loss_ev_s && (loss_q != 8'hFF)) begin
      loss_d = loss_q + 8'd1;
    end else begin
      loss_d = loss_q;
    end
  end

  // Statistics registers, cleared only by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q <= 8'd0;
      loss_q  <= 8'd0;
    end else begin
      retry_q <= retry_d;
      loss_q  <= loss_d;
    end
  end

  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;
`else
  logic unused_ev_s;
  assign unused_ev_s = retry_ev_s ^ loss_ev_s;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed scenarios plus randomized lock activity vs a phase model.
module tb_pll_lock_sequencer;
  localparam int RST = 4;
  localparam int TO  = 20;
  localparam int ST  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst, sys_rst_n, lock_ok;
  logic [1:0] state_o;
`ifdef PLL_LOCK_STATS_EN
  logic [7:0] retry_cnt, loss_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pll_lock_sequencer #(
    .RST_CYCLES(RST), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(ST), .CNT_W(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .lock_ok(lock_ok),
`ifdef PLL_LOCK_STATS_EN
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt),
`endif
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Reference model: phase (0 reset,1 wait,2 stable,3 run) plus cycles elapsed in the phase.
  logic m_s1, m_lk;
  int   m_phase, m_elapsed, mn_phase, mn_elapsed;
  logic [4:0] m_out, dut_out;

  always_comb begin
    mn_phase   = m_phase;
    mn_elapsed = m_elapsed + 1;
    case (m_phase)
      0: if (m_elapsed == RST - 1) begin mn_phase = 1; mn_elapsed = 0; end
      1: begin
        if (m_lk) begin mn_phase = 2; mn_elapsed = 0; end
        else if (m_elapsed == TO - 1) begin mn_phase = 0; mn_elapsed = 0; end
      end
      2: begin
        if (!m_lk) begin mn_phase = 1; mn_elapsed = 0; end
        else if (m_elapsed == ST - 1) begin mn_phase = 3; mn_elapsed = 0; end
      end
      default: begin
        mn_elapsed = 0;
        if (!m_lk) mn_phase = 1;
      end
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 <= 1'b0; m_lk <= 1'b0; m_phase <= 0; m_elapsed <= 0;
    end else begin
      m_s1 <= pll_locked; m_lk <= m_s1; m_phase <= mn_phase; m_elapsed <= mn_elapsed;
    end
  end

  assign m_out   = {m_phase == 0, m_phase == 3, m_phase == 3, 2'(m_phase)};
  assign dut_out = {pll_rst, sys_rst_n, lock_ok, state_o};

`ifdef PLL_LOCK_STATS_EN
  int m_retry, m_loss;
  // Stats model: timeouts are waits that reach their last cycle without lock; losses are lock drops in run.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_retry <= 0; m_loss <= 0;
    end else begin
      if (m_phase == 1 && !m_lk && m_elapsed == TO - 1 && m_retry < 255) m_retry <= m_retry + 1;
      if (m_phase == 3 && !m_lk && m_loss < 255) m_loss <= m_loss + 1;
    end
  end
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    pll_locked = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    pll_locked = 1'b0;
    #1;
    n_checks++;
    if (dut_out !== 5'b10000) begin n_fail++; $display("FAIL reset_outputs: got %b expected %b", dut_out, 5'b10000); end
    tick(); tick();
    n_checks++;
    if (dut_out !== 5'b10000) begin n_fail++; $display("FAIL reset_held: got %b expected %b", dut_out, 5'b10000); end
`ifdef PLL_LOCK_STATS_EN
    n_checks++;
    if (retry_cnt !== 8'd0 || loss_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", retry_cnt, loss_cnt); end
`endif
    #1 rst_n = 1'b1;
  endtask

  task automatic test_powerup();
    do_reset();
    for (int e = 1; e <= 26; e++) begin
      tick();
      n_checks++;
      if (pll_rst !== (e < RST)) begin n_fail++; $display("FAIL powerup_pll_rst e=%0d: got %b expected %b", e, pll_rst, e < RST); end
      n_checks++;
      if (sys_rst_n !== (e >= 21)) begin n_fail++; $display("FAIL powerup_sys_rst_n e=%0d: got %b expected %b", e, sys_rst_n, e >= 21); end
      n_checks++;
      if (dut_out !== m_out) begin n_fail++; $display("FAIL powerup_model e=%0d: got %b expected %b", e, dut_out, m_out); end
      if (e == 10) pll_locked = 1'b1;
    end
    n_checks++;
    if (lock_ok !== 1'b1) begin n_fail++; $display("FAIL powerup_lock_ok: got %b expected 1", lock_ok); end
  endtask

  task automatic test_no_lock();
    do_reset();
    for (int e = 1; e <= 72; e++) begin
      tick();
      n_checks++;
      if (pll_rst !== ((e % 24) < RST)) begin n_fail++; $display("FAIL nolock_pll_rst e=%0d: got %b expected %b", e, pll_rst, (e % 24) < RST); end
      n_checks++;
      if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL nolock_sys_rst_n e=%0d: got %b expected 0", e, sys_rst_n); end
      n_checks++;
      if (dut_out !== m_out) begin n_fail++; $display("FAIL nolock_model e=%0d: got %b expected %b", e, dut_out, m_out); end
    end
`ifdef PLL_LOCK_STATS_EN
    n_checks++;
    if (retry_cnt !== 8'd3) begin n_fail++; $display("FAIL nolock_retry3: got %0d expected 3", retry_cnt); end
    for (int e = 73; e <= 260 * 24; e++) tick();
    n_checks++;
    if (retry_cnt !== 8'd255) begin n_fail++; $display("FAIL retry_saturate: got %0d expected 255", retry_cnt); end
    n_checks++;
    if (int'(retry_cnt) != m_retry) begin n_fail++; $display("FAIL retry_model: got %0d expected %0d", retry_cnt, m_retry); end
`endif
  endtask

  task automatic test_glitch();
    do_reset();
    pll_locked = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      tick();
      n_checks++;
      if (sys_rst_n !== (e >= 21)) begin n_fail++; $display("FAIL glitch_sys_rst_n e=%0d: got %b expected %b", e, sys_rst_n, e >= 21); end
      n_checks++;
      if (dut_out !== m_out) begin n_fail++; $display("FAIL glitch_model e=%0d: got %b expected %b", e, dut_out, m_out); end
      if (e == 11 || e == 12 || e == 13) begin
        n_checks++;
        if (state_o !== ((e == 12) ? 2'd1 : 2'd2)) begin n_fail++; $display("FAIL glitch_state e=%0d: got %0d expected %0d", e, state_o, (e == 12) ? 1 : 2); end
      end
      if (e == 9) pll_locked = 1'b0;
      if (e == 10) pll_locked = 1'b1;
    end
  endtask

  task automatic test_lock_loss();
    tick(); tick();
    pll_locked = 1'b0;
    for (int f = 1; f <= 20; f++) begin
      tick();
      n_checks++;
      if (sys_rst_n !== (f < 3 || f >= 16)) begin n_fail++; $display("FAIL loss_sys_rst_n f=%0d: got %b expected %b", f, sys_rst_n, f < 3 || f >= 16); end
      n_checks++;
      if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL loss_pll_rst f=%0d: got %b expected 0", f, pll_rst); end
      n_checks++;
      if (dut_out !== m_out) begin n_fail++; $display("FAIL loss_model f=%0d: got %b expected %b", f, dut_out, m_out); end
      if (f == 3) begin
        n_checks++;
        if (state_o !== 2'd1) begin n_fail++; $display("FAIL loss_state: got %0d expected 1", state_o); end
      end
      if (f == 5) pll_locked = 1'b1;
    end
`ifdef PLL_LOCK_STATS_EN
    n_checks++;
    if (loss_cnt !== 8'd1 || retry_cnt !== 8'd0) begin n_fail++; $display("FAIL loss_stats: got %0d/%0d expected 1/0", loss_cnt, retry_cnt); end
`endif
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int e = 1; e <= 26; e++) begin
      tick();
      n_checks++;
      if (dut_out !== m_out) begin n_fail++; $display("FAIL simul_model e=%0d: got %b expected %b", e, dut_out, m_out); end
      if (e == 24) begin
        n_checks++;
        if (state_o !== 2'd2 || pll_rst !== 1'b0) begin n_fail++; $display("FAIL simul_lock_wins: got state %0d pll_rst %b expected 2/0", state_o, pll_rst); end
      end
      if (e == 21) pll_locked = 1'b1;
    end
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      tick();
      n_checks++;
      if (dut_out !== m_out) begin n_fail++; $display("FAIL late_lock_model e=%0d: got %b expected %b", e, dut_out, m_out); end
      if (e == 24) begin
        n_checks++;
        if (state_o !== 2'd0 || pll_rst !== 1'b1) begin n_fail++; $display("FAIL late_lock_retry: got state %0d pll_rst %b expected 0/1", state_o, pll_rst); end
      end
      if (e == 29) begin
        n_checks++;
        if (state_o !== 2'd2) begin n_fail++; $display("FAIL late_lock_stable: got %0d expected 2", state_o); end
      end
      if (e == 22) pll_locked = 1'b1;
    end
  endtask

  task automatic test_async_reset();
    n_checks++;
    if (lock_ok !== 1'b1) begin n_fail++; $display("FAIL async_pre_run: got %b expected 1", lock_ok); end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut_out !== 5'b10000) begin n_fail++; $display("FAIL async_reset_immediate: got %b expected %b", dut_out, 5'b10000); end
    #1 rst_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      n_checks++;
      if (pll_rst !== (e < RST)) begin n_fail++; $display("FAIL async_repeat_pll_rst e=%0d: got %b expected %b", e, pll_rst, e < RST); end
      n_checks++;
      if (sys_rst_n !== (e >= 13)) begin n_fail++; $display("FAIL async_repeat_sys_rst_n e=%0d: got %b expected %b", e, sys_rst_n, e >= 13); end
    end
  endtask

  task automatic test_random();
    int hold;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      hold = 0;
      for (int c = 0; c < 400; c++) begin
        if (hold == 0) begin
          pll_locked = ~pll_locked;
          hold = pll_locked ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 30));
        end
        tick();
        hold--;
        n_checks++;
        if (dut_out !== m_out) begin n_fail++; $display("FAIL random_model it=%0d c=%0d: got %b expected %b", it, c, dut_out, m_out); end
`ifdef PLL_LOCK_STATS_EN
        n_checks++;
        if (int'(retry_cnt) != m_retry || int'(loss_cnt) != m_loss) begin n_fail++; $display("FAIL random_stats it=%0d c=%0d: got %0d/%0d expected %0d/%0d", it, c, retry_cnt, loss_cnt, m_retry, m_loss); end
`endif
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_powerup();
    test_no_lock();
    test_glitch();
    test_lock_loss();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Free-running supervisor on the 50 MHz reference clock that drives the audio/video PLL's active-high reset and consumes its `locked` output.
- Pulses the PLL reset at power-up, then waits for lock with a timeout and retries if lock is not reached.
- Requires lock to be continuously stable before releasing the system reset (`sys_rst_n`) to the 18.432/6.144 MHz core.
- Re-enters the lock sequence whenever lock is lost.

Parameters:
- RST_CYCLES, 16: clk cycles `pll_rst` is held high per reset pulse (min 1).
- LOCK_TIMEOUT, 500000: clk cycles in WAIT_LOCK before a retry (10 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive synced-locked cycles required before `sys_rst_n` is released (min 1).
- CNT_W, 20: width of the shared down-counter. Must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) - 1.

Ports:
- clk, input, 1: 50 MHz free-running reference clock (same net as the PLL `refclk`).
- rst_n, input, 1: asynchronous active-low reset.
- pll_locked, input, 1: PLL `locked`, asynchronous to clk.
- pll_rst, output, 1: active-high reset to the PLL `rst` input.
- sys_rst_n, output, 1: active-low core reset. Consumers re-synchronise it into the core clock domain.
- lock_ok, output, 1: high while in RUN.
- state_o, output, 2: current state encoding, for debug.

Behaviour:
- Reset values while rst_n=0:
  - pll_rst=1, sys_rst_n=0, lock_ok=0, state=PLL_RESET.
  - Counter = RST_CYCLES-1; sync flops = 0.
  - After rst_n rises, the first active edge starts the PLL_RESET count.
- pll_locked passes through a 2-flop synchroniser; `lk` denotes the second flop. Latency from a pll_locked edge to `lk` is 2 clk edges.
- State encoding: PLL_RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3. A single down-counter `cnt` is reloaded on every state entry.
- PLL_RESET:
  - pll_rst=1, sys_rst_n=0.
  - Decrement cnt. At cnt==0, go to WAIT_LOCK with cnt=LOCK_TIMEOUT-1.
  - pll_rst is therefore high for exactly RST_CYCLES cycles after reset release.
- WAIT_LOCK:
  - pll_rst=0, sys_rst_n=0.
  - If lk=1, go to STABLE with cnt=STABLE_CYCLES-1.
  - Else if cnt==0, go to PLL_RESET with cnt=RST_CYCLES-1 (retry).
  - Else decrement cnt.
  - If lk=1 and cnt==0 occur in the same cycle, lock wins and the block goes to STABLE.
- STABLE:
  - pll_rst=0, sys_rst_n=0.
  - If lk=0, go to WAIT_LOCK with cnt=LOCK_TIMEOUT-1. This is a glitch reject: the timeout restarts.
  - Else if cnt==0, go to RUN.
  - Else decrement cnt.
- RUN:
  - pll_rst=0. sys_rst_n=1 and lock_ok=1 from the first RUN cycle.
  - If lk=0, go to WAIT_LOCK with cnt=LOCK_TIMEOUT-1. sys_rst_n falls on the same edge the state leaves RUN.
  - The PLL is not re-reset unless WAIT_LOCK then times out.
- All outputs are registered and decoded from the state register, so there are no combinational paths from pll_locked.
- Release latency from synced lock: sys_rst_n rises STABLE_CYCLES+1 clk edges after the first `lk`=1 sample in WAIT_LOCK.
- Counter arithmetic is unsigned CNT_W. The counter never underflows; every zero condition causes a reload.
- rst_n asserted mid-operation returns all outputs to reset values asynchronously, including pll_rst=1 immediately.

Optional Feature:
- Macro: PLL_LOCK_STATS_EN.
- When defined, two extra outputs are added:
  - retry_cnt, output, 8: WAIT_LOCK timeouts.
  - loss_cnt, output, 8: RUN-to-WAIT_LOCK transitions.
- Both counters saturate at 255, are cleared only by rst_n, and increment on the same edge as the transition they count.
- When not defined, neither port nor their logic exists; all other behaviour is identical.

Test Plan (bench params RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8):
- Power-up, locked rises 10 cycles after reset:
  - pll_rst is high for exactly 4 cycles after rst_n release.
  - sys_rst_n rises exactly 8+1 edges after the first lk=1 sample.
  - lock_ok=1.
- Locked never rises:
  - Repeating pattern of pll_rst high 4 cycles, then low 20 cycles.
  - sys_rst_n stays 0.
  - retry_cnt (stats build) reaches 3 after 3 timeouts.
- Locked glitches low for 1 cycle (held 1 cycle, so it survives the synchroniser) while in STABLE at cnt=3:
  - Return to WAIT_LOCK, then STABLE restarts a full 8 cycles.
  - sys_rst_n is not released early.
- Lock loss in RUN (locked low for 5 cycles, then high):
  - sys_rst_n falls 3 edges after the pll_locked fall.
  - No pll_rst pulse occurs.
  - sys_rst_n re-releases after lock is re-established plus 8+1 edges.
  - loss_cnt=1 (stats build).
- Simultaneous event: lk rises on the cycle WAIT_LOCK cnt==0 -> state goes to STABLE, not PLL_RESET.
- rst_n pulsed low mid-RUN -> pll_rst=1, sys_rst_n=0, state=0 without waiting for a clk edge; the full sequence then repeats.
